// File: rtl/cdb_pkg.sv
// Shared types and helpers for the CDB write-back arbiter.
// Payload widths, the cdb_entry_t bundle and the round-robin pointer step.
package cdb_pkg;

   localparam int CDB_DATA_W = 32;
   localparam int CDB_PREG_W = 7;
   localparam int CDB_TAG_W  = 5;
   localparam int CDB_PC_W   = 32;

   typedef struct packed {
      logic [CDB_DATA_W-1:0] val;
      logic [CDB_PREG_W-1:0] addr;
      logic [CDB_TAG_W-1:0]  tag;
      logic [CDB_PC_W-1:0]   pc;
      logic                  br_taken;
   } cdb_entry_t;

   function automatic int next_rr_ptr(input int last, input int n);
      return (last + 1 >= n) ? 0 : last + 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Single round-robin pick: first set request at or after start, cyclically.
// Produces a one-hot grant and a found flag.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] start,
   output logic [N-1:0]  grant,
   output logic          found
);

   // cyclic scan from start, first hit wins
   always_comb begin
      int idx;
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(start) + k) % N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the CDB slots between result producers.
// Optional stall counters are built when CDB_ARB_STATS_EN is defined.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int NUM_CDB_PORTS = 2,
   parameter int DATA_W        = CDB_DATA_W,
   parameter int PREG_W        = CDB_PREG_W,
   parameter int TAG_W         = CDB_TAG_W,
   parameter int PC_W          = CDB_PC_W
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      flush,
   input  logic [NUM_REQ-1:0]                        req_valid,
   output logic [NUM_REQ-1:0]                        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]                 req_val,
   input  logic [NUM_REQ*PREG_W-1:0]                 req_addr,
   input  logic [NUM_REQ*TAG_W-1:0]                  req_tag,
   input  logic [NUM_REQ*PC_W-1:0]                   req_pc,
   input  logic [NUM_REQ-1:0]                        req_br_taken,
   output logic [NUM_CDB_PORTS-1:0]                  cdb_valid,
   output logic [NUM_CDB_PORTS*DATA_W-1:0]           cdb_val,
   output logic [NUM_CDB_PORTS*PREG_W-1:0]           cdb_addr,
   output logic [NUM_CDB_PORTS*TAG_W-1:0]            cdb_tag,
   output logic [NUM_CDB_PORTS*PC_W-1:0]             cdb_pc,
   output logic [NUM_CDB_PORTS-1:0]                  cdb_br_taken,
   output logic [NUM_CDB_PORTS*$clog2(NUM_REQ)-1:0]  cdb_src
`ifdef CDB_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]                     stall_cnt
`endif
);

   localparam int SW = $clog2(NUM_REQ);

   logic [SW-1:0]                        rr_ptr;
   logic [NUM_CDB_PORTS:0][NUM_REQ-1:0]  avail;
   logic [NUM_CDB_PORTS-1:0][NUM_REQ-1:0] gnt;
   logic [NUM_CDB_PORTS-1:0]             found;
   logic [NUM_CDB_PORTS-1:0][SW-1:0]     gidx;
   logic [SW-1:0]                        last;
   logic                                 any;

   // flush blocks every grant for this cycle
   assign avail[0]  = flush ? '0 : req_valid;
   assign req_ready = avail[0] & ~avail[NUM_CDB_PORTS];

   // each stage takes the next remaining requester from rr_ptr
   for (genvar k = 0; k < NUM_CDB_PORTS; k++) begin : g_pick
      rr_pick #(.N(NUM_REQ), .PW(SW)) u_pick (
         .req   (avail[k]),
         .start (rr_ptr),
         .grant (gnt[k]),
         .found (found[k])
      );
      assign avail[k+1] = avail[k] & ~gnt[k];
   end

   // one-hot grants to producer indices
   always_comb begin
      gidx = '0;
      for (int k = 0; k < NUM_CDB_PORTS; k++)
         for (int i = 0; i < NUM_REQ; i++)
            if (gnt[k][i]) gidx[k] = SW'(i);
   end

   // slots fill densely, so the highest found slot holds the last grant
   always_comb begin
      last = '0;
      any  = 1'b0;
      for (int k = 0; k < NUM_CDB_PORTS; k++)
         if (found[k]) begin
            last = gidx[k];
            any  = 1'b1;
         end
   end

   // register granted payloads onto their slots; idle slots keep payload
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr       <= '0;
         cdb_valid    <= '0;
         cdb_val      <= '0;
         cdb_addr     <= '0;
         cdb_tag      <= '0;
         cdb_pc       <= '0;
         cdb_br_taken <= '0;
         cdb_src      <= '0;
      end else begin
         if (any)
            rr_ptr <= SW'(next_rr_ptr(int'(last), NUM_REQ));
         cdb_valid <= found;
         for (int k = 0; k < NUM_CDB_PORTS; k++) begin
            if (found[k]) begin
               cdb_val[k*DATA_W +: DATA_W] <=
                  req_val[int'(gidx[k])*DATA_W +: DATA_W];
               cdb_addr[k*PREG_W +: PREG_W] <=
                  req_addr[int'(gidx[k])*PREG_W +: PREG_W];
               cdb_tag[k*TAG_W +: TAG_W] <=
                  req_tag[int'(gidx[k])*TAG_W +: TAG_W];
               cdb_pc[k*PC_W +: PC_W] <=
                  req_pc[int'(gidx[k])*PC_W +: PC_W];
               cdb_br_taken[k] <= req_br_taken[gidx[k]];
               cdb_src[k*SW +: SW] <= gidx[k];
            end
         end
      end
   end

`ifdef CDB_ARB_STATS_EN
   // saturating count of cycles each producer waited without a grant
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++)
            if (req_valid[i] && !req_ready[i] && !flush &&
                stall_cnt[i*16 +: 16] != 16'hFFFF)
               stall_cnt[i*16 +: 16] <= stall_cnt[i*16 +: 16] + 16'd1;
      end
   end
`endif

endmodule
